pulse_timing_meter: RTL and testbench

PULSE_TIMING_METER -- requirements
Module: pulse_timing_meter

---
 rtl/pulse_meas_pkg.sv | 31 +++
 rtl/pulse_meas_chan.sv | 94 +++++++++
 rtl/pulse_timing_meter.sv | 51 +++++
 tb/tb_pulse_timing_meter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// Shared encodings and defaults for the multi-channel pulse timing meter.
package pulse_meas_pkg;

  localparam int unsigned DEF_CH          = 4;
  localparam int unsigned DEF_CW          = 32;
  localparam int unsigned DEF_SYNC_STAGES = 3;

  typedef enum logic [1:0] {
    MODE_HIGH   = 2'b00,
    MODE_LOW    = 2'b01,
    MODE_PERIOD = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_COUNT = 2'b10
  } chan_state_e;

  // Encoding 2'b11 is an alias of the period mode.
  function automatic mode_e norm_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'b00:   r = MODE_HIGH;
      2'b01:   r = MODE_LOW;
      default: r = MODE_PERIOD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_meas_chan.sv
// One measurement channel: synchroniser, edge detector, FSM, saturating counter
// and sticky overflow flag.
module pulse_meas_chan
  import pulse_meas_pkg::*;
#(
  parameter int unsigned CW          = DEF_CW,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          meaclk,
  input  logic          rst,
  input  logic          sig,
  input  logic          abort,
  input  mode_e         mode,
  input  logic          clr_ovf,
  output logic [CW-1:0] result,
  output logic          valid,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;
  logic [SYNC_STAGES:0]   primed;
  logic                   rise, fall;
  logic [1:0]             rise_q, fall_q;
  logic                   start_ev, end_ev, sat;
  chan_state_e            state;
  logic [CW-1:0]          count;

  always_ff @(posedge meaclk) begin
    if (rst) begin
      sync   <= '0;
      dly    <= 1'b0;
      primed <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig};
      dly    <= sync[SYNC_STAGES-1];
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
      rise_q <= {rise_q[0], rise};
      fall_q <= {fall_q[0], fall};
    end
  end

  // Edges are only trusted once real samples have reached the delay flop, so
  // the refill after reset never looks like a transition.
  assign rise = primed[SYNC_STAGES] & sync[SYNC_STAGES-1] & ~dly;
  assign fall = primed[SYNC_STAGES] & ~sync[SYNC_STAGES-1] & dly;

  assign start_ev = (mode == MODE_LOW)  ? fall_q[1] : rise_q[1];
  assign end_ev   = (mode == MODE_HIGH) ? fall_q[1] : rise_q[1];
  assign sat      = (count == CNT_MAX);

  always_ff @(posedge meaclk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      result <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARMED;
          ST_ARMED: begin
            if (start_ev) begin
              state <= ST_COUNT;
              count <= '0;
            end
          end
          ST_COUNT: begin
            if (end_ev) begin
              result <= sat ? CNT_MAX : count + 1'b1;
              valid  <= 1'b1;
              if (sat) ovf <= 1'b1;
              if (mode == MODE_PERIOD) count <= '0;
              else                     state <= ST_ARMED;
            end else if (!sat) begin
              count <= count + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_timing_meter.sv
// Multi-channel pulse width / period meter: mode register, abort generation
// and per-channel instances.
module pulse_timing_meter
  import pulse_meas_pkg::*;
#(
  parameter int unsigned CH          = DEF_CH,
  parameter int unsigned CW          = DEF_CW,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             meaclk,
  input  logic             rst,
  input  logic [CH-1:0]    sig_in,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             clr_ovf,
  output logic [CH*CW-1:0] result,
  output logic [CH-1:0]    valid,
  output logic [CH-1:0]    ovf
);

  logic [1:0] mode_q;
  logic       abort;
  mode_e      mode_eff;

  always_ff @(posedge meaclk) begin
    if (rst) mode_q <= '0;
    else     mode_q <= mode;
  end

  // Any raw mode transition, including 10<->11, restarts every channel.
  assign abort    = ~enable | (mode != mode_q);
  assign mode_eff = norm_mode(mode_q);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pulse_meas_chan #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .meaclk  (meaclk),
      .rst     (rst),
      .sig     (sig_in[i]),
      .abort   (abort),
      .mode    (mode_eff),
      .clr_ovf (clr_ovf),
      .result  (result[i*CW +: CW]),
      .valid   (valid[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_pulse_timing_meter.sv
// Directed scoreboard bench: a 4x32 meter and a 1x8 meter for saturation cases.
module tb_pulse_timing_meter;

  localparam int LAT = 6;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   sig;
  logic         enable;
  logic [1:0]   mode;
  logic         clr;
  logic [127:0] res;
  logic [3:0]   valid;
  logic [3:0]   ovf;

  logic [0:0]   sig8;
  logic         enable8;
  logic [1:0]   mode8;
  logic         clr8;
  logic [7:0]   res8;
  logic [0:0]   valid8;
  logic [0:0]   ovf8;

  logic [4:0]   v_all;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;
  exp_t         exp_q[5][$];
  logic [31:0]  last_val[5];
  exp_t         mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_timing_meter #(.CH(4), .CW(32), .SYNC_STAGES(3)) dut (
    .meaclk (clk), .rst (rst), .sig_in (sig), .enable (enable), .mode (mode),
    .clr_ovf (clr), .result (res), .valid (valid), .ovf (ovf)
  );

  pulse_timing_meter #(.CH(1), .CW(8), .SYNC_STAGES(3)) dut8 (
    .meaclk (clk), .rst (rst), .sig_in (sig8), .enable (enable8), .mode (mode8),
    .clr_ovf (clr8), .result (res8), .valid (valid8), .ovf (ovf8)
  );

  assign v_all = {valid8, valid};

  function automatic logic [31:0] res_of(input int c);
    if (c == 4) return {24'd0, res8};
    return res[c*32 +: 32];
  endfunction

  function automatic logic ovf_of(input int c);
    if (c == 4) return ovf8[0];
    return ovf[c];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input int c, input logic [31:0] v, input logic o);
    exp_t e;
    e.cyc = cyc + LAT;
    e.val = v;
    e.o   = o;
    exp_q[c].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 5; c++) begin
      if (v_all[c]) begin
        n_checks++;
        assert (exp_q[c].size() > 0) else begin
          n_err++;
          $error("FAIL spurious_valid_ch%0d: got valid=1 result=%0d expected no valid (cyc %0d)",
                 c, res_of(c), cyc);
        end
        if (exp_q[c].size() > 0) begin
          mon_e = exp_q[c].pop_front();
          last_val[c] = mon_e.val;
          chk($sformatf("result_ch%0d", c), res_of(c), mon_e.val);
          chk($sformatf("latency_ch%0d", c), 32'(cyc), 32'(mon_e.cyc));
          chk($sformatf("ovf_ch%0d", c), 32'(ovf_of(c)), 32'(mon_e.o));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x;
    for (int c = 0; c < 5; c++) last_val[c] = '0;
    rst = 1'b1; sig = 4'b0010; enable = 1'b1; mode = 2'b00; clr = 1'b0;
    sig8 = 1'b0; enable8 = 1'b1; mode8 = 2'b00; clr8 = 1'b0;
    tick(3);
    for (int c = 0; c < 5; c++) chk($sformatf("rst_result_ch%0d", c), res_of(c), 32'd0);
    chk("rst_valid", 32'(v_all), 32'd0);
    chk("rst_ovf", 32'({ovf8, ovf}), 32'd0);
    rst = 1'b0;
    tick(10);

    // high width, single channel and simultaneous channels
    sig[0] = 1'b1; tick(10); sig[0] = 1'b0; push(0, 10, 1'b0); tick(12);
    sig[0] = 1'b1; sig[3] = 1'b1; tick(6);
    sig[0] = 1'b0; sig[3] = 1'b0; push(0, 6, 1'b0); push(3, 6, 1'b0); tick(12);

    // low width, including a single-cycle low
    mode = 2'b01; tick(8);
    sig[1] = 1'b0; tick(7); sig[1] = 1'b1; push(1, 7, 1'b0); tick(8);
    sig[1] = 1'b0; tick(1); sig[1] = 1'b1; push(1, 1, 1'b0); tick(12);

    // period mode, back-to-back periods, then the 11 alias
    mode = 2'b10; tick(8);
    for (int p = 0; p < 5; p++) begin
      sig[2] = 1'b1; if (p > 0) push(2, 16, 1'b0); tick(8);
      sig[2] = 1'b0; tick(8);
    end
    mode = 2'b11; tick(8);
    for (int p = 0; p < 3; p++) begin
      sig[2] = 1'b1; if (p > 0) push(2, 20, 1'b0); tick(10);
      sig[2] = 1'b0; tick(10);
    end

    // enable raised mid-pulse: partial pulse discarded
    enable = 1'b0; mode = 2'b00; sig[3] = 1'b1; tick(10);
    enable = 1'b1; tick(10);
    sig[3] = 1'b0; tick(10);
    sig[3] = 1'b1; tick(12); sig[3] = 1'b0; push(3, 12, 1'b0); tick(12);
    chk("held_ch3", res_of(3), last_val[3]);

    // mode change mid-pulse aborts
    sig[0] = 1'b1; tick(8); mode = 2'b10; tick(5);
    sig[0] = 1'b0; tick(12);
    chk("abort_held_ch0", res_of(0), last_val[0]);
    sig[0] = 1'b1; tick(10); sig[0] = 1'b0; tick(10);
    sig[0] = 1'b1; push(0, 20, 1'b0); tick(4); sig[0] = 1'b0; tick(4);
    mode = 2'b00; tick(10);

    // reset mid-pulse aborts and clears
    sig[0] = 1'b1; tick(8);
    rst = 1'b1; tick(1);
    for (int c = 0; c < 4; c++) chk($sformatf("midrst_result_ch%0d", c), res_of(c), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    for (int c = 0; c < 5; c++) last_val[c] = '0;
    rst = 1'b0; tick(5);
    sig[0] = 1'b0; tick(12);
    chk("post_rst_held_ch0", res_of(0), 32'd0);
    sig[0] = 1'b1; tick(9); sig[0] = 1'b0; push(0, 9, 1'b0); tick(12);

    // 8-bit saturation, clear, boundaries, clear coinciding with new set
    sig8 = 1'b1; tick(300); sig8 = 1'b0; push(4, 255, 1'b1); tick(12);
    chk("ovf8_sticky", 32'(ovf8), 32'd1);
    clr8 = 1'b1; tick(1); clr8 = 1'b0;
    chk("ovf8_cleared", 32'(ovf8), 32'd0);
    tick(4);
    sig8 = 1'b1; tick(255); sig8 = 1'b0; push(4, 255, 1'b0); tick(12);
    sig8 = 1'b1; tick(256); sig8 = 1'b0; push(4, 255, 1'b1); tick(12);
    clr8 = 1'b1; tick(1); clr8 = 1'b0; tick(4);
    sig8 = 1'b1; tick(300); sig8 = 1'b0; push(4, 255, 1'b1);
    x = cyc + LAT;
    while (cyc < x - 1) @(negedge clk);
    clr8 = 1'b1; tick(1); clr8 = 1'b0;
    chk("ovf8_set_wins", 32'(ovf8), 32'd1);
    tick(20);

    for (int c = 0; c < 5; c++) begin
      chk($sformatf("drain_ch%0d", c), 32'(exp_q[c].size()), 32'd0);
      chk($sformatf("final_held_ch%0d", c), res_of(c), last_val[c]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
